// File: rtl/phase_meas_sequencer_if.sv
// rtl/phase_meas_sequencer_if.sv - control, echo and result signals of the phase sequencer
interface phase_meas_sequencer_if #(
  parameter int CNT_W      = 8,
  parameter int NMEAS_LOG2 = 4
);
  logic                  go;
  logic                  abort;
  logic                  start_out;
  logic                  stop_in;
  logic [CNT_W-1:0]      phase_in;
  logic                  busy;
  logic                  result_valid;
  logic                  result_ack;
  logic [CNT_W-1:0]      avg;
  logic [CNT_W-1:0]      min_ph;
  logic [CNT_W-1:0]      max_ph;
  logic [NMEAS_LOG2:0]   n_timeout;
  logic                  err;

  // Register block / bench side
  modport master (
    output go, abort, stop_in, phase_in, result_ack,
    input  start_out, busy, result_valid, avg, min_ph, max_ph, n_timeout, err
  );

  // Sequencer side
  modport slave (
    input  go, abort, stop_in, phase_in, result_ack,
    output start_out, busy, result_valid, avg, min_ph, max_ph, n_timeout, err
  );
endinterface

// File: rtl/phase_meas_sequencer.sv
// rtl/phase_meas_sequencer.sv - burst sequencer for the start/echo phase counter
module phase_meas_sequencer #(
  parameter int CNT_W      = 8,
  parameter int NMEAS_LOG2 = 4,
  parameter int TIMEOUT    = 250,
  parameter int SETTLE     = 2,
  parameter int GAP        = 8
) (
  input  logic                   clk_fast,
  input  logic                   reset_n,
  phase_meas_sequencer_if.slave  bus
);

  localparam int SUM_W = CNT_W + NMEAS_LOG2;
  localparam int TMR_W = CNT_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_FIRE   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_REPORT = 3'd6;

  localparam logic [TMR_W-1:0]      T_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]      S_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0]      G_LAST = TMR_W'(GAP - 1);
  localparam logic [NMEAS_LOG2:0]   N_GOOD = {1'b1, {NMEAS_LOG2{1'b0}}};
  localparam logic [NMEAS_LOG2+1:0] N_ATT  = {1'b1, {(NMEAS_LOG2+1){1'b0}}};

  logic [2:0]              state;
  logic [TMR_W-1:0]        timer;
  logic [SUM_W-1:0]        sum;
  logic [NMEAS_LOG2:0]     good_cnt;
  logic [NMEAS_LOG2+1:0]   att_cnt;
  logic [NMEAS_LOG2:0]     tmo_cnt;
  logic [CNT_W-1:0]        min_r;
  logic [CNT_W-1:0]        max_r;

  // Reported values live apart from the accumulators so they survive the next burst's clear
  logic [CNT_W-1:0]        avg_o;
  logic [CNT_W-1:0]        min_o;
  logic [CNT_W-1:0]        max_o;
  logic [NMEAS_LOG2:0]     tmo_o;
  logic                    err_o;
  logic                    valid_o;

  // Timed-out attempts count saturates instead of wrapping
  logic [NMEAS_LOG2:0]     tmo_next;
  assign tmo_next = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;

  // Burst state machine, accumulators and report registers
  always_ff @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      timer    <= '0;
      sum      <= '0;
      good_cnt <= '0;
      att_cnt  <= '0;
      tmo_cnt  <= '0;
      min_r    <= '1;
      max_r    <= '0;
      avg_o    <= '0;
      min_o    <= '0;
      max_o    <= '0;
      tmo_o    <= '0;
      err_o    <= 1'b0;
      valid_o  <= 1'b0;
    end else if (bus.abort) begin
      state   <= S_IDLE;
      timer   <= '0;
      valid_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.go) begin
            sum      <= '0;
            good_cnt <= '0;
            att_cnt  <= '0;
            tmo_cnt  <= '0;
            min_r    <= '1;
            max_r    <= '0;
            timer    <= '0;
            state    <= S_ARM;
          end
        end
        S_ARM: begin
          // The counter ignores start while the echo line is still high
          if (!bus.stop_in) begin
            timer <= '0;
            state <= S_FIRE;
          end else if (timer == T_LAST) begin
            tmo_cnt <= tmo_next;
            att_cnt <= att_cnt + 1'b1;
            timer   <= '0;
            state   <= S_GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_FIRE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // An echo arriving on the timeout cycle still counts as good
          if (bus.stop_in) begin
            timer <= '0;
            state <= S_SETTLE;
          end else if (timer == T_LAST) begin
            tmo_cnt <= tmo_next;
            att_cnt <= att_cnt + 1'b1;
            timer   <= '0;
            state   <= S_GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_SETTLE: begin
          if (timer == S_LAST) begin
            sum      <= sum + {{NMEAS_LOG2{1'b0}}, bus.phase_in};
            good_cnt <= good_cnt + 1'b1;
            if (bus.phase_in < min_r) min_r <= bus.phase_in;
            if (bus.phase_in > max_r) max_r <= bus.phase_in;
            att_cnt  <= att_cnt + 1'b1;
            timer    <= '0;
            state    <= S_GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_GAP: begin
          if (timer == G_LAST) begin
            timer <= '0;
            if (good_cnt == N_GOOD || att_cnt == N_ATT) begin
              avg_o   <= sum[SUM_W-1:NMEAS_LOG2];
              min_o   <= min_r;
              max_o   <= max_r;
              tmo_o   <= tmo_cnt;
              err_o   <= (good_cnt != N_GOOD);
              valid_o <= 1'b1;
              state   <= S_REPORT;
            end else begin
              state <= S_ARM;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_REPORT: begin
          if (bus.result_ack) begin
            valid_o <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign bus.start_out    = (state == S_FIRE) && !bus.abort;
  assign bus.busy         = (state != S_IDLE);
  assign bus.result_valid = valid_o;
  assign bus.avg          = avg_o;
  assign bus.min_ph       = min_o;
  assign bus.max_ph       = max_o;
  assign bus.n_timeout    = tmo_o;
  assign bus.err          = err_o;

endmodule

// File: tb/tb_phase_meas_sequencer.sv
// tb/tb_phase_meas_sequencer.sv - directed bench for the phase measurement sequencer
module tb_phase_meas_sequencer;

  logic clk_fast = 1'b0;
  logic reset_n  = 1'b0;

  always #5 clk_fast = ~clk_fast;

  phase_meas_sequencer_if #(.CNT_W(8), .NMEAS_LOG2(4)) bus ();

  phase_meas_sequencer #(
    .CNT_W(8), .NMEAS_LOG2(4), .TIMEOUT(250), .SETTLE(2), .GAP(8)
  ) dut (
    .clk_fast (clk_fast),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic        echo_stop  = 1'b0;
  logic        stop_force = 1'b0;
  logic        echo_en    = 1'b1;
  logic        alt_mode   = 1'b0;
  logic [7:0]  echo_phase = 8'd0;
  logic [31:0] drop_mask  = 32'd0;
  int          n_start    = 0;
  int          n_echo     = 0;
  int          start_base = 0;
  int          wide_cnt   = 0;
  int          echo_d     = 20;
  int          ai;

  assign bus.stop_in  = echo_stop | stop_force;
  assign bus.phase_in = echo_phase;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Echo model: answers each start pulse echo_d cycles later unless the attempt is dropped
  always begin
    @(negedge clk_fast);
    if (bus.start_out === 1'b1) begin
      n_start++;
      ai = n_start - start_base - 1;
      @(negedge clk_fast);
      if (bus.start_out === 1'b1) wide_cnt++;
      if (echo_en && !(ai >= 0 && ai < 32 && drop_mask[ai])) begin
        repeat (echo_d - 1) @(negedge clk_fast);
        echo_phase = alt_mode ? (n_echo[0] ? 8'd30 : 8'd10) : 8'd20;
        echo_stop  = 1'b1;
        n_echo++;
        repeat (3) @(negedge clk_fast);
        echo_stop  = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_fast);
      #1;
    end
  endtask

  task automatic pulse_go;
    bus.go = 1'b1;
    tick(1);
    bus.go = 1'b0;
  endtask

  task automatic wait_report(input int budget);
    int cnt = 0;
    while (bus.result_valid !== 1'b1 && cnt < budget) begin
      tick(1);
      cnt++;
    end
    chk("report_seen", int'(bus.result_valid), 1);
  endtask

  task automatic wait_start;
    int cnt = 0;
    while (n_start == start_base && cnt < 100) begin
      tick(1);
      cnt++;
    end
    chk("start_seen", n_start - start_base, 1);
  endtask

  task automatic check_report(input string p, input int e_avg, input int e_min, input int e_max,
                              input int e_tmo, input int e_err, input int e_starts, input int budget);
    wait_report(budget);
    chk({p, "_avg"},    int'(bus.avg),       e_avg);
    chk({p, "_min"},    int'(bus.min_ph),    e_min);
    chk({p, "_max"},    int'(bus.max_ph),    e_max);
    chk({p, "_ntmo"},   int'(bus.n_timeout), e_tmo);
    chk({p, "_err"},    int'(bus.err),       e_err);
    chk({p, "_starts"}, n_start - start_base, e_starts);
    tick(3);
    chk({p, "_valid_held"}, int'(bus.result_valid), 1);
    pulse_go;
    chk({p, "_avg_stable"}, int'(bus.avg), e_avg);
    bus.result_ack = 1'b1;
    tick(1);
    bus.result_ack = 1'b0;
    chk({p, "_valid_drop"}, int'(bus.result_valid), 0);
    chk({p, "_idle"},       int'(bus.busy), 0);
    tick(2);
    chk({p, "_go_ignored"}, int'(bus.busy), 0);
  endtask

  task automatic run_burst(input string p, input int e_avg, input int e_min, input int e_max,
                           input int e_tmo, input int e_err, input int e_starts, input int budget);
    start_base = n_start;
    pulse_go;
    check_report(p, e_avg, e_min, e_max, e_tmo, e_err, e_starts, budget);
  endtask

  initial begin
    bus.go         = 1'b0;
    bus.abort      = 1'b0;
    bus.result_ack = 1'b0;

    tick(3);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_valid", int'(bus.result_valid), 0);
    chk("rst_start", int'(bus.start_out), 0);
    chk("rst_avg",   int'(bus.avg), 0);
    chk("rst_min",   int'(bus.min_ph), 0);
    chk("rst_max",   int'(bus.max_ph), 0);
    chk("rst_ntmo",  int'(bus.n_timeout), 0);
    chk("rst_err",   int'(bus.err), 0);
    reset_n = 1'b1;
    tick(2);

    run_burst("const", 20, 20, 20, 0, 0, 16, 2000);

    alt_mode = 1'b1;
    run_burst("alt", 20, 10, 30, 0, 0, 16, 2000);

    drop_mask = 32'h0000_0044;
    run_burst("drop", 20, 10, 30, 2, 0, 18, 4000);
    drop_mask = 32'd0;
    alt_mode  = 1'b0;

    echo_en = 1'b0;
    run_burst("nostop", 0, 255, 0, 31, 1, 32, 20000);
    echo_en = 1'b1;

    stop_force = 1'b1;
    start_base = n_start;
    pulse_go;
    tick(10);
    chk("held_no_start", n_start - start_base, 0);
    chk("held_busy", int'(bus.busy), 1);
    stop_force = 1'b0;
    check_report("held", 20, 20, 20, 0, 0, 16, 2000);

    start_base = n_start;
    pulse_go;
    wait_start;
    tick(5);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    chk("abort_busy",  int'(bus.busy), 0);
    chk("abort_start", int'(bus.start_out), 0);
    chk("abort_valid", int'(bus.result_valid), 0);
    tick(40);
    chk("abort_no_report", int'(bus.result_valid), 0);
    chk("abort_avg_kept",  int'(bus.avg), 20);
    run_burst("post_abort", 20, 20, 20, 0, 0, 16, 2000);

    start_base = n_start;
    pulse_go;
    wait_start;
    tick(echo_d);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy",  int'(bus.busy), 0);
    chk("rst_mid_start", int'(bus.start_out), 0);
    chk("rst_mid_valid", int'(bus.result_valid), 0);
    chk("rst_mid_avg",   int'(bus.avg), 0);
    tick(2);
    reset_n = 1'b1;
    tick(40);
    chk("rst_mid_no_report", int'(bus.result_valid), 0);
    alt_mode = 1'b1;
    run_burst("post_rst", 20, 10, 30, 0, 0, 16, 2000);

    chk("start_width", wide_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_meas_sequencer.md
Name: phase_meas_sequencer

Overview:
- Drives the fast-clock start/echo phase counter through a programmed burst of measurements.
- Each measurement: fires a one-cycle start pulse, waits for the echo, and captures the counter's clk-tick result. Timed-out attempts are retried.
- Reports average, min and max over 2^NMEAS_LOG2 good samples through a valid/ack handshake.
- Sits between the slow-control register block and the phase counter, in the clk_fast domain.

Parameters:
- CNT_W, 8: width of phase counter result and of avg/min/max.
- NMEAS_LOG2, 4: log2 of the number of good samples per burst (16).
- TIMEOUT, 250: max cycles in WAIT before an attempt is declared timed out; must be < 2^CNT_W.
- SETTLE, 2: cycles from stop_in seen high to capture of phase_in. The counter result is stable from the cycle after stop.
- GAP, 8: idle cycles between attempts, so the echo path drains.

Ports:
- clk_fast  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- go  in  1  one-cycle request to start a burst; ignored unless IDLE
- abort  in  1  synchronous; forces IDLE from any state, no report
- start_out  out  1  one-cycle start pulse to the phase counter
- stop_in  in  1  echo, already synchronous to clk_fast
- phase_in  in  CNT_W  phase counter result
- busy  out  1  high in every state except IDLE
- result_valid  out  1  held high in REPORT until acknowledged
- result_ack  in  1  consumer accept
- avg  out  CNT_W  sum of good samples >> NMEAS_LOG2 (truncating)
- min_ph  out  CNT_W  smallest good sample
- max_ph  out  CNT_W  largest good sample
- n_timeout  out  NMEAS_LOG2+1  timed-out attempts in burst, saturating
- err  out  1  burst ended by attempt limit

Behaviour:
- Reset values: all outputs 0; min_ph register = all-ones internally; state IDLE; accumulators cleared.
- IDLE: go=1 -> clear sum, good count, attempt count, n_timeout; min=all-ones, max=0; go to ARM.
- ARM: wait for stop_in=0, so the counter can start (start is ignored while stop is high).
  - stop_in=0 -> FIRE.
  - Stuck high for TIMEOUT cycles -> counts as a timed-out attempt -> GAP.
- FIRE: start_out=1 for exactly this one cycle; timer cleared -> WAIT.
- WAIT: timer increments each cycle.
  - stop_in=1 -> SETTLE.
  - Timer reaches TIMEOUT with no stop -> n_timeout+1 (saturate) -> GAP.
  - stop_in in the same cycle as timeout: stop wins.
- SETTLE: count SETTLE cycles, then sample phase_in:
  - sum += phase_in, at width CNT_W+NMEAS_LOG2, never overflows;
  - good count +1;
  - update min/max; a value equal to the current min/max leaves it unchanged.
  - Then go to GAP.
- GAP: count GAP cycles; attempt count +1 on entry (every attempt, good or timed out).
  - Good count = 2^NMEAS_LOG2 -> REPORT.
  - Else attempt count = 2^(NMEAS_LOG2+1) -> REPORT with err=1.
  - Else -> ARM.
- REPORT: avg/min_ph/max_ph/n_timeout/err registered on entry and stable while result_valid=1.
  - result_valid rises on the REPORT entry cycle.
  - result_ack=1 while valid -> result_valid=0 next cycle -> IDLE.
  - Outputs retain values until the next burst starts.
  - go during REPORT is ignored.
- err=1 with 0 good samples: avg=0, min_ph=all-ones, max_ph=0. With partial samples, avg still divides by 2^NMEAS_LOG2.
- abort: next state IDLE; start_out forced 0 that cycle; result_valid cleared; outputs keep their last reported values.
- Reset mid-burst: immediate return to reset values, asynchronous; no partial report.
- Latency, ideal echo of D cycles: one attempt = 1 (ARM) + 1 (FIRE) + D + SETTLE + GAP cycles.

Test Plan:
- Reset, then go with echo 20 cycles after every start_out and phase_in=20 -> 16 start_out pulses, each 1 cycle wide; result_valid; avg=20, min_ph=20, max_ph=20, n_timeout=0, err=0.
- phase_in alternating 10/30 over 16 samples -> avg=20, min_ph=10, max_ph=30.
- No echo on attempts 3 and 7, good otherwise -> 18 start_out pulses; n_timeout=2; err=0; avg correct over the 16 good samples.
- stop_in tied low -> 32 attempts, then REPORT; err=1, n_timeout saturates at 31, min_ph=0xFF, max_ph=0, avg=0.
- stop_in held high at go for 10 cycles -> no start_out until stop_in falls; then normal burst.
- abort during WAIT, and reset_n low during SETTLE -> IDLE next cycle, busy=0, no result_valid, start_out=0; a following go runs a full correct burst.
